layer_dma_sequencer: RTL and testbench
======================================

Name: layer_dma_sequencer

Overview:
- Sits directly downstream of the layer controller; consumes its `layer_start` pulse and the latched layer config (H, W, Cin, Cout, weight/ifm/ofm addresses).
- Runs three phases in order: weight fetch, IFM fetch, OFM writeback. Each phase is cut into AXI-legal burst commands for the read/write datamovers.
- Pulses `layer_done` back to the layer controller once every burst of every phase has completed.

Parameters:
- AXI_ADDR_W, 32, byte-address width.
- DATA_BYTES, 8, bytes per data beat; power of two.
- MAX_BURST, 16, max beats per burst, 1..256.
- MAX_OUTSTANDING, 4, max issued-but-uncompleted bursts per channel.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset; asynchronous, active-low.
- layer_start  in  1  one-cycle pulse that starts a layer.
- H, W, Cin, Cout  in  16 each  layer geometry; sampled on layer_start.
- weight_addr, ifm_addr, ofm_addr  in  AXI_ADDR_W each  phase base addresses; sampled on layer_start.
- layer_done  out  1  one-cycle pulse; layer finished.
- busy  out  1  high from the cycle after accepted start through the done cycle.
- phase  out  2  0 idle, 1 weights, 2 ifm, 3 ofm.
- rd_cmd_valid  out  1  read command valid.
- rd_cmd_ready  in  1  read command ready.
- rd_cmd_addr  out  AXI_ADDR_W  read burst start address.
- rd_cmd_len  out  8  read burst length, AXI encoding (beats-1).
- rd_cmd_done  in  1  pulse: one read burst completed.
- wr_cmd_valid, wr_cmd_ready, wr_cmd_addr, wr_cmd_len, wr_cmd_done: same roles for writes.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- States: IDLE -> SETUP -> WGT -> IFM -> OFM -> DONE -> IDLE.
- IDLE: layer_start latches all config inputs and moves to SETUP. layer_start in any other state is ignored.
- SETUP (1 cycle) computes byte counts in 48-bit arithmetic:
  - wgt = Cin*Cout
  - ifm = H*W*Cin
  - ofm = H*W*Cout
- Beat counts: beats = ceil(bytes/DATA_BYTES), held in 40-bit counters.
- Base addresses have their low log2(DATA_BYTES) bits forced to 0.
- Phase with 0 beats: skipped. It spends exactly 1 cycle in its state, with no command issued.
- Burst size = min(remaining, MAX_BURST, beats_to_4KB), where beats_to_4KB = (4096 - addr[11:0]) / DATA_BYTES. No burst ever crosses a 4 KB boundary.
- Command handshake:
  - valid is asserted only when remaining>0 and outstanding<MAX_OUTSTANDING.
  - addr and len stay stable while valid && !ready.
  - On valid&&ready: addr += beats*DATA_BYTES, remaining -= beats, outstanding++.
- cmd_done: outstanding-- on each pulse.
  - Issue and done in the same cycle: outstanding unchanged.
  - done while outstanding==0: ignored, no underflow.
- Phase completes when remaining==0 and outstanding==0. The next state is entered the following cycle.
- Channel use: WGT and IFM drive the rd_* channel only; OFM drives the wr_* channel only. The unused channel's valid stays 0.
- DONE: layer_done=1 for exactly one cycle, phase=0, busy drops the next cycle.
- Latency: with ready held 1 and zero-size phases, layer_start to layer_done = 5 cycles.
- Reset mid-operation: returns immediately to IDLE with all outputs 0. In-flight dones arriving after reset are ignored.

Decomposition:
- Shared package holds:
  - state encodings;
  - phase codes;
  - the 4 KB boundary constant;
  - a function computing beats-to-boundary.
- One sub-module, burst_splitter, is natural:
  - inputs: base address, beat count, cmd ready, done;
  - outputs: cmd valid/addr/len and phase_complete;
  - it owns the outstanding counter.
- Instantiate burst_splitter once and mux it between the read and write channels by phase.

Test Plan:
- Cin=3, Cout=16, H=W=224, weight_addr=0, ifm_addr=0, ofm_addr=0x8100_0000, ready=1, done returned 3 cycles after each issue:
  - weights: one read, addr 0, len 5;
  - IFM: 18816 beats, 1176 reads of len 15;
  - OFM: 100352 beats, 6272 writes of len 15 starting at 0x8100_0000;
  - layer_done pulses once.
- 4 KB boundary: weight_addr=0x0000_0FF0, Cin=Cout=16 (32 beats) -> reads at 0x0FF0 len 1, 0x1000 len 15, 0x1080 len 13.
- Outstanding limit: done withheld -> exactly 4 commands issued, then valid=0. Release one done -> exactly one more command issued.
- Backpressure: rd_cmd_ready=0 for 10 cycles -> addr and len held constant, no double-count.
- Zero size: Cin=0 -> weight and IFM phases skipped. OFM still runs for H*W*Cout bytes, and layer_done pulses.
- rst_n low mid-IFM -> all outputs 0 asynchronously. A later layer_start runs a clean full layer.

Source files
------------

// File: rtl/layer_dma_sequencer_pkg.sv
// Shared types and helpers for the layer DMA sequencer.
// State/phase codes and 4 KB page arithmetic.
package layer_dma_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WGT,
    S_IFM,
    S_OFM,
    S_DONE
  } state_t;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_WGT  = 2'd1;
  localparam logic [1:0] PH_IFM  = 2'd2;
  localparam logic [1:0] PH_OFM  = 2'd3;

  localparam int unsigned PAGE_BYTES = 4096;

  // Beats left before the next 4 KB page for a beat-aligned offset.
  function automatic logic [12:0] beats_to_4kb(
    input logic [11:0] off,
    input int unsigned shift
  );
    logic [12:0] room;
    room = 13'(PAGE_BYTES) - {1'b0, off};
    return room >> shift;
  endfunction

endpackage

// File: rtl/layer_dma_sequencer_burst_splitter.sv
// Cuts one phase into AXI-legal bursts.
// Tracks remaining beats and in-flight bursts.
module layer_dma_sequencer_burst_splitter
  import layer_dma_sequencer_pkg::*;
#(
  parameter int AXI_ADDR_W      = 32,
  parameter int DATA_BYTES      = 8,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ld,
  input  logic [AXI_ADDR_W-1:0] ld_base,
  input  logic [39:0]           ld_beats,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [AXI_ADDR_W-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  input  logic                  cmd_done,
  output logic                  phase_complete
);

  localparam int SHIFT = $clog2(DATA_BYTES);
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [AXI_ADDR_W-1:0] ALIGN =
    ~AXI_ADDR_W'(DATA_BYTES - 1);

  logic [AXI_ADDR_W-1:0] addr_q;
  logic [39:0]           rem_q;
  logic [OW-1:0]         outs_q;
  logic [12:0]           room;
  logic [39:0]           burst;
  logic [AXI_ADDR_W-1:0] adv;
  logic                  issue;
  logic                  retire;

  // Burst size: remaining, capped by max burst and page room.
  always_comb begin
    room  = beats_to_4kb(addr_q[11:0], SHIFT);
    burst = rem_q;
    if (burst > 40'(MAX_BURST))
      burst = 40'(MAX_BURST);
    if (burst > {27'd0, room})
      burst = {27'd0, room};
  end

  assign adv = AXI_ADDR_W'(burst[8:0]) << SHIFT;

  assign cmd_valid = (rem_q != '0) &&
                     (outs_q < OW'(MAX_OUTSTANDING));
  assign issue     = cmd_valid && cmd_ready;
  assign retire    = cmd_done && (outs_q != '0);

  assign cmd_addr = cmd_valid ? addr_q : '0;
  assign cmd_len  = cmd_valid ? 8'(burst - 40'd1) : 8'd0;

  assign phase_complete = (rem_q == '0) &&
                          (outs_q == '0);

  // Address and beat bookkeeping; load restarts a phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (ld) begin
      addr_q <= ld_base & ALIGN;
      rem_q  <= ld_beats;
    end else if (issue) begin
      addr_q <= addr_q + adv;
      rem_q  <= rem_q - burst;
    end
  end

  // In-flight burst count; stray dones at zero are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outs_q <= '0;
    end else begin
      unique case ({issue, retire})
        2'b10:   outs_q <= outs_q + OW'(1);
        2'b01:   outs_q <= outs_q - OW'(1);
        default: outs_q <= outs_q;
      endcase
    end
  end

endmodule

// File: rtl/layer_dma_sequencer.sv
// Layer DMA sequencer: weights, IFM, then OFM.
// One burst splitter shared across read/write channels.
module layer_dma_sequencer
  import layer_dma_sequencer_pkg::*;
#(
  parameter int AXI_ADDR_W      = 32,
  parameter int DATA_BYTES      = 8,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  layer_start,
  input  logic [15:0]           H,
  input  logic [15:0]           W,
  input  logic [15:0]           Cin,
  input  logic [15:0]           Cout,
  input  logic [AXI_ADDR_W-1:0] weight_addr,
  input  logic [AXI_ADDR_W-1:0] ifm_addr,
  input  logic [AXI_ADDR_W-1:0] ofm_addr,
  output logic                  layer_done,
  output logic                  busy,
  output logic [1:0]            phase,
  output logic                  rd_cmd_valid,
  input  logic                  rd_cmd_ready,
  output logic [AXI_ADDR_W-1:0] rd_cmd_addr,
  output logic [7:0]            rd_cmd_len,
  input  logic                  rd_cmd_done,
  output logic                  wr_cmd_valid,
  input  logic                  wr_cmd_ready,
  output logic [AXI_ADDR_W-1:0] wr_cmd_addr,
  output logic [7:0]            wr_cmd_len,
  input  logic                  wr_cmd_done
);

  localparam int SHIFT = $clog2(DATA_BYTES);

  state_t                state_q;
  logic [15:0]           h_q;
  logic [15:0]           w_q;
  logic [15:0]           cin_q;
  logic [15:0]           cout_q;
  logic [AXI_ADDR_W-1:0] wa_q;
  logic [AXI_ADDR_W-1:0] ia_q;
  logic [AXI_ADDR_W-1:0] oa_q;

  logic [47:0] wgt_bytes;
  logic [47:0] ifm_bytes;
  logic [47:0] ofm_bytes;
  logic [39:0] wgt_beats;
  logic [39:0] ifm_beats_q;
  logic [39:0] ofm_beats_q;

  logic                  ld;
  logic [AXI_ADDR_W-1:0] ld_base;
  logic [39:0]           ld_beats;
  logic                  rd_sel;
  logic                  wr_sel;
  logic                  sp_valid;
  logic                  sp_ready;
  logic                  sp_done;
  logic [AXI_ADDR_W-1:0] sp_addr;
  logic [7:0]            sp_len;
  logic                  sp_complete;

  function automatic logic [39:0] to_beats(
    input logic [47:0] bytes
  );
    return 40'(({1'b0, bytes} +
                49'(DATA_BYTES - 1)) >> SHIFT);
  endfunction

  assign wgt_bytes = {32'd0, cin_q} * {32'd0, cout_q};
  assign ifm_bytes = {32'd0, h_q} * {32'd0, w_q} *
                     {32'd0, cin_q};
  assign ofm_bytes = {32'd0, h_q} * {32'd0, w_q} *
                     {32'd0, cout_q};
  assign wgt_beats = to_beats(wgt_bytes);

  // Capture layer config on an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q    <= '0;
      w_q    <= '0;
      cin_q  <= '0;
      cout_q <= '0;
      wa_q   <= '0;
      ia_q   <= '0;
      oa_q   <= '0;
    end else if (state_q == S_IDLE && layer_start) begin
      h_q    <= H;
      w_q    <= W;
      cin_q  <= Cin;
      cout_q <= Cout;
      wa_q   <= weight_addr;
      ia_q   <= ifm_addr;
      oa_q   <= ofm_addr;
    end
  end

  // Later-phase beat counts frozen during setup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifm_beats_q <= '0;
      ofm_beats_q <= '0;
    end else if (state_q == S_SETUP) begin
      ifm_beats_q <= to_beats(ifm_bytes);
      ofm_beats_q <= to_beats(ofm_bytes);
    end
  end

  // Load the splitter on the edge that enters each phase.
  always_comb begin
    ld       = 1'b0;
    ld_base  = wa_q;
    ld_beats = wgt_beats;
    unique case (state_q)
      S_SETUP: ld = 1'b1;
      S_WGT: begin
        ld       = sp_complete;
        ld_base  = ia_q;
        ld_beats = ifm_beats_q;
      end
      S_IFM: begin
        ld       = sp_complete;
        ld_base  = oa_q;
        ld_beats = ofm_beats_q;
      end
      default: ld = 1'b0;
    endcase
  end

  assign rd_sel = (state_q == S_WGT) ||
                  (state_q == S_IFM);
  assign wr_sel = (state_q == S_OFM);

  // Route handshake inputs from the active channel.
  always_comb begin
    sp_ready = 1'b0;
    sp_done  = 1'b0;
    unique case (1'b1)
      rd_sel: begin
        sp_ready = rd_cmd_ready;
        sp_done  = rd_cmd_done;
      end
      wr_sel: begin
        sp_ready = wr_cmd_ready;
        sp_done  = wr_cmd_done;
      end
      default: begin
        sp_ready = 1'b0;
        sp_done  = 1'b0;
      end
    endcase
  end

  assign rd_cmd_valid = rd_sel & sp_valid;
  assign rd_cmd_addr  = rd_sel ? sp_addr : '0;
  assign rd_cmd_len   = rd_sel ? sp_len : '0;
  assign wr_cmd_valid = wr_sel & sp_valid;
  assign wr_cmd_addr  = wr_sel ? sp_addr : '0;
  assign wr_cmd_len   = wr_sel ? sp_len : '0;

  layer_dma_sequencer_burst_splitter #(
    .AXI_ADDR_W      (AXI_ADDR_W),
    .DATA_BYTES      (DATA_BYTES),
    .MAX_BURST       (MAX_BURST),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_burst_splitter (
    .clk            (clk),
    .rst_n          (rst_n),
    .ld             (ld),
    .ld_base        (ld_base),
    .ld_beats       (ld_beats),
    .cmd_valid      (sp_valid),
    .cmd_ready      (sp_ready),
    .cmd_addr       (sp_addr),
    .cmd_len        (sp_len),
    .cmd_done       (sp_done),
    .phase_complete (sp_complete)
  );

  // Phase sequencing with registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase      <= PH_IDLE;
      busy       <= 1'b0;
      layer_done <= 1'b0;
    end else begin
      layer_done <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (layer_start) begin
            state_q <= S_SETUP;
            busy    <= 1'b1;
          end
        end
        S_SETUP: begin
          state_q <= S_WGT;
          phase   <= PH_WGT;
        end
        S_WGT: begin
          if (sp_complete) begin
            state_q <= S_IFM;
            phase   <= PH_IFM;
          end
        end
        S_IFM: begin
          if (sp_complete) begin
            state_q <= S_OFM;
            phase   <= PH_OFM;
          end
        end
        S_OFM: begin
          if (sp_complete) begin
            state_q    <= S_DONE;
            phase      <= PH_IDLE;
            layer_done <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_dma_sequencer.sv
// Bench for layer_dma_sequencer: command-list model,
// per-cycle compare, and directed scenarios.
module tb_layer_dma_sequencer;

  localparam int DB = 8;
  localparam int MB = 16;
  localparam int MO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        layer_start = 1'b0;
  logic [15:0] h = '0;
  logic [15:0] w = '0;
  logic [15:0] cin = '0;
  logic [15:0] cout = '0;
  logic [31:0] weight_addr = '0;
  logic [31:0] ifm_addr = '0;
  logic [31:0] ofm_addr = '0;
  logic        layer_done;
  logic        busy;
  logic [1:0]  phase;
  logic        rd_cmd_valid;
  logic        rd_cmd_ready = 1'b1;
  logic [31:0] rd_cmd_addr;
  logic [7:0]  rd_cmd_len;
  logic        rd_cmd_done = 1'b0;
  logic        wr_cmd_valid;
  logic        wr_cmd_ready = 1'b1;
  logic [31:0] wr_cmd_addr;
  logic [7:0]  wr_cmd_len;
  logic        wr_cmd_done = 1'b0;

  always #5 clk = ~clk;

  layer_dma_sequencer #(
    .AXI_ADDR_W      (32),
    .DATA_BYTES      (DB),
    .MAX_BURST       (MB),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .layer_start  (layer_start),
    .H            (h),
    .W            (w),
    .Cin          (cin),
    .Cout         (cout),
    .weight_addr  (weight_addr),
    .ifm_addr     (ifm_addr),
    .ofm_addr     (ofm_addr),
    .layer_done   (layer_done),
    .busy         (busy),
    .phase        (phase),
    .rd_cmd_valid (rd_cmd_valid),
    .rd_cmd_ready (rd_cmd_ready),
    .rd_cmd_addr  (rd_cmd_addr),
    .rd_cmd_len   (rd_cmd_len),
    .rd_cmd_done  (rd_cmd_done),
    .wr_cmd_valid (wr_cmd_valid),
    .wr_cmd_ready (wr_cmd_ready),
    .wr_cmd_addr  (wr_cmd_addr),
    .wr_cmd_len   (wr_cmd_len),
    .wr_cmd_done  (wr_cmd_done)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  cmd_t exp_q[$];
  int   rd_due[$];
  int   wr_due[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rd_fires = 0;
  int   wr_fires = 0;
  int   done_cnt = 0;
  int   out_rd = 0;
  int   out_wr = 0;
  bit   auto_done = 1'b1;
  int   rel_req = 0;
  int   rel_ack = 0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h",
               name, act, req);
    end
  endtask

  // Expected bursts for one phase from the splitting rules.
  task automatic model_phase(input bit wr,
                             input logic [31:0] base,
                             input longint bytes);
    longint beats;
    longint n;
    longint room;
    logic [31:0] a;
    a = base & ~32'(DB - 1);
    beats = (bytes + DB - 1) / DB;
    while (beats > 0) begin
      room = (4096 - (a % 4096)) / DB;
      n = beats;
      if (n > MB) n = MB;
      if (n > room) n = room;
      exp_q.push_back('{wr, a, 8'(n - 1)});
      a = a + 32'(n * DB);
      beats = beats - n;
    end
  endtask

  task automatic model_layer(input logic [15:0] th, tw,
                             input logic [15:0] tci, tco,
                             input logic [31:0] twa, tia,
                             input logic [31:0] toa);
    longint hw;
    hw = longint'(th) * longint'(tw);
    model_phase(1'b0, twa, longint'(tci) * longint'(tco));
    model_phase(1'b0, tia, hw * longint'(tci));
    model_phase(1'b1, toa, hw * longint'(tco));
  endtask

  task automatic start_layer(input logic [15:0] th, tw,
                             input logic [15:0] tci, tco,
                             input logic [31:0] twa, tia,
                             input logic [31:0] toa);
    h = th;
    w = tw;
    cin = tci;
    cout = tco;
    weight_addr = twa;
    ifm_addr = tia;
    ofm_addr = toa;
    layer_start = 1'b1;
    @(posedge clk); #1;
    layer_start = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done(input string name,
                           input int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick(1);
      n++;
    end
    check({name, "_done_seen"}, done_cnt != d0, 1);
    tick(4);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_busy_clear"}, busy, 0);
    check({name, "_queue_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_idle(input string name);
    check({name, "_ctrl"},
          {layer_done, busy, phase,
           rd_cmd_valid, wr_cmd_valid}, 0);
    check({name, "_rd_addr"}, rd_cmd_addr, 0);
    check({name, "_rd_len"}, rd_cmd_len, 0);
    check({name, "_wr_addr"}, wr_cmd_addr, 0);
    check({name, "_wr_len"}, wr_cmd_len, 0);
  endtask

  // Per-cycle compare against the model, plus done responder.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      rd_cmd_done = 1'b0;
      wr_cmd_done = 1'b0;
    end else begin
      check("chan_excl", rd_cmd_valid && wr_cmd_valid, 0);
      if (rd_cmd_valid) begin
        check("rd_phase", phase == 1 || phase == 2, 1);
        check("rd_outstanding", out_rd < MO, 1);
        if (exp_q.size() == 0) begin
          check("rd_unexpected", 1, 0);
        end else begin
          check("rd_chan", exp_q[0].wr, 0);
          check("rd_addr", rd_cmd_addr, exp_q[0].addr);
          check("rd_len", rd_cmd_len, exp_q[0].len);
        end
        if (rd_cmd_ready) begin
          rd_fires++;
          out_rd++;
          rd_due.push_back(cyc + 3);
          if (exp_q.size() > 0) exp_q.delete(0);
        end
      end
      if (wr_cmd_valid) begin
        check("wr_phase", phase, 3);
        check("wr_outstanding", out_wr < MO, 1);
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 1, 0);
        end else begin
          check("wr_chan", exp_q[0].wr, 1);
          check("wr_addr", wr_cmd_addr, exp_q[0].addr);
          check("wr_len", wr_cmd_len, exp_q[0].len);
        end
        if (wr_cmd_ready) begin
          wr_fires++;
          out_wr++;
          wr_due.push_back(cyc + 3);
          if (exp_q.size() > 0) exp_q.delete(0);
        end
      end
      if (layer_done) begin
        done_cnt++;
        check("done_queue_empty", exp_q.size(), 0);
        check("done_outstanding", out_rd + out_wr, 0);
      end
      rd_cmd_done = 1'b0;
      if (rd_due.size() > 0) begin
        if (auto_done ? (rd_due[0] <= cyc)
                      : (rel_req != rel_ack)) begin
          rd_due.delete(0);
          rd_cmd_done = 1'b1;
          if (out_rd > 0) out_rd--;
          if (!auto_done) rel_ack++;
        end
      end
      wr_cmd_done = 1'b0;
      if (wr_due.size() > 0 && wr_due[0] <= cyc) begin
        wr_due.delete(0);
        wr_cmd_done = 1'b1;
        if (out_wr > 0) out_wr--;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ph_exp[7] = '{0, 1, 2, 3, 0, 0, 0};
    int lat;
    int f_rd;
    int f_wr;
    int n;

    // Reset state
    tick(3);
    check_idle("reset");
    rst_n = 1'b1;
    tick(2);

    // Empty layer: start to done latency and phase walk
    start_layer(0, 0, 0, 0, 0, 0, 0);
    lat = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (layer_done && lat == 0) lat = i + 1;
      check("lat_phase", phase, ph_exp[i]);
      if (i == 4) check("lat_busy_done_cycle", busy, 1);
      if (i == 5) check("lat_busy_drop", busy, 0);
    end
    check("latency", lat, 5);
    tick(1);

    // Full layer from the example geometry
    model_layer(224, 224, 3, 16, 0, 0, 32'h8100_0000);
    check("full_model_size", exp_q.size(), 7449);
    check("full_model_wgt_len", exp_q[0].len, 5);
    check("full_model_ifm_last", exp_q[1176].addr,
          32'h0002_4B80);
    check("full_model_ofm_first", exp_q[1177].addr,
          32'h8100_0000);
    check("full_model_ofm_last", exp_q[7448].addr,
          32'h810C_3F80);
    f_rd = rd_fires;
    f_wr = wr_fires;
    start_layer(224, 224, 3, 16, 0, 0, 32'h8100_0000);
    wait_done("full", 40000);
    check("full_rd_count", rd_fires - f_rd, 1177);
    check("full_wr_count", wr_fires - f_wr, 6272);

    // 4 KB boundary split
    model_layer(0, 0, 16, 16, 32'h0FF0, 0, 0);
    check("page_model_size", exp_q.size(), 3);
    check("page_model_a0", {exp_q[0].addr, exp_q[0].len},
          {32'h0FF0, 8'd1});
    check("page_model_a1", {exp_q[1].addr, exp_q[1].len},
          {32'h1000, 8'd15});
    check("page_model_a2", {exp_q[2].addr, exp_q[2].len},
          {32'h1080, 8'd13});
    start_layer(0, 0, 16, 16, 32'h0FF0, 0, 0);
    wait_done("page", 200);

    // Outstanding limit with dones withheld
    auto_done = 1'b0;
    model_layer(0, 0, 16, 64, 32'h2000, 0, 0);
    f_rd = rd_fires;
    start_layer(0, 0, 16, 64, 32'h2000, 0, 0);
    tick(15);
    check("outs_issued", rd_fires - f_rd, 4);
    check("outs_valid_low", rd_cmd_valid, 0);
    start_layer(7, 7, 7, 7, 32'h5000, 32'h6000, 32'h7000);
    rel_req++;
    tick(10);
    check("outs_one_more", rd_fires - f_rd, 5);
    check("outs_valid_low2", rd_cmd_valid, 0);
    auto_done = 1'b1;
    wait_done("outs", 400);
    check("outs_total", rd_fires - f_rd, 8);

    // Backpressure holds the command
    rd_cmd_ready = 1'b0;
    model_layer(0, 0, 16, 16, 32'h40, 0, 0);
    f_rd = rd_fires;
    start_layer(0, 0, 16, 16, 32'h40, 0, 0);
    n = 0;
    while (!rd_cmd_valid && n < 20) begin
      tick(1);
      n++;
    end
    check("bp_valid_seen", rd_cmd_valid, 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("bp_hold", {rd_cmd_valid, rd_cmd_addr,
                        rd_cmd_len},
            {1'b1, 32'h40, 8'd15});
    end
    check("bp_no_issue", rd_fires - f_rd, 0);
    rd_cmd_ready = 1'b1;
    wait_done("bp", 200);
    check("bp_total", rd_fires - f_rd, 2);

    // Zero Cin: weights and IFM skipped
    model_layer(2, 4, 0, 8, 32'h100, 32'h200, 32'h3000);
    check("zero_model", {exp_q[0].wr, exp_q[0].addr,
                         exp_q[0].len},
          {1'b1, 32'h3000, 8'd7});
    f_rd = rd_fires;
    f_wr = wr_fires;
    start_layer(2, 4, 0, 8, 32'h100, 32'h200, 32'h3000);
    wait_done("zero", 200);
    check("zero_rd_count", rd_fires - f_rd, 0);
    check("zero_wr_count", wr_fires - f_wr, 1);

    // Reset in the middle of IFM
    model_layer(32, 32, 3, 16, 0, 32'h10000, 32'h20000);
    f_rd = rd_fires;
    start_layer(32, 32, 3, 16, 0, 32'h10000, 32'h20000);
    n = 0;
    while (!(phase == 2 && rd_fires - f_rd >= 4) &&
           n < 200) begin
      tick(1);
      n++;
    end
    check("mid_ifm_reached", phase, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    exp_q.delete();
    out_rd = 0;
    out_wr = 0;
    tick(3);
    rst_n = 1'b1;
    tick(8);
    check_idle("post_reset");

    // Clean layer after reset, unaligned bases
    model_layer(8, 8, 2, 4, 32'h1003, 32'h2005, 32'h3007);
    check("clean_model_size", exp_q.size(), 4);
    check("clean_model_align", exp_q[0].addr, 32'h1000);
    f_rd = rd_fires;
    f_wr = wr_fires;
    start_layer(8, 8, 2, 4, 32'h1003, 32'h2005, 32'h3007);
    wait_done("clean", 300);
    check("clean_rd_count", rd_fires - f_rd, 2);
    check("clean_wr_count", wr_fires - f_wr, 2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
